// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: command opcodes, FSM states and
// reset defaults for the configuration registers.
package counter_seq_pkg;

  localparam logic [1:0] OP_CLEAR    = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_STOP     = 2'd2;
  localparam logic [1:0] OP_LOAD_CFG = 2'd3;

  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Fill bits replicated to the configured widths at reset.
  localparam logic CFG_LIMIT_RST_FILL    = 1'b1;
  localparam logic CFG_PRESCALE_RST_FILL = 1'b0;
  localparam logic CFG_DIR_RST           = 1'b0;
  localparam logic CFG_ONESHOT_RST       = 1'b0;

endpackage

// File: rtl/counter_core.sv
// Loadable up/down counter register with a terminal-value comparator.
module counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             dir,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] y,
  output logic             at_terminal
);

  logic [WIDTH-1:0] y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= '0;
    end else if (load) begin
      y_q <= load_value;
    end else if (enable) begin
      y_q <= dir ? (y_q - 1'b1) : (y_q + 1'b1);
    end
  end

  assign y           = y_q;
  assign at_terminal = (y_q == terminal);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a prescaled 4-bit up/down counter: owns the
// FSM, configuration registers, prescaler and status pulses.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic                  cfg_dir,
  input  logic                  cfg_oneshot,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic [WIDTH-1:0]      y,
  output logic                  tc_pulse,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0]      limit_q, limit_d;
  logic                  dir_q, dir_d;
  logic                  oneshot_q, oneshot_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  tc_q, tc_d;
  logic                  err_q, err_d;

  logic                  load, enable, at_terminal;
  logic [WIDTH-1:0]      load_value, start_val, terminal;

  assign start_val = (dir_q == DIR_DOWN) ? limit_q : '0;
  assign terminal  = (dir_q == DIR_DOWN) ? '0 : limit_q;

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .dir        (dir_q),
    .terminal   (terminal),
    .y          (y),
    .at_terminal(at_terminal)
  );

  always_comb begin
    state_d    = state_q;
    psc_d      = psc_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    oneshot_d  = oneshot_q;
    prescale_d = prescale_q;
    tc_d       = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;
    load_value = start_val;
    enable     = 1'b0;

    // Any accepted command pre-empts a step in the same cycle.
    if (cmd_valid) begin
      unique case (cmd_op)
        OP_CLEAR: begin
          state_d    = StIdle;
          psc_d      = '0;
          load       = 1'b1;
          load_value = '0;
        end
        OP_START: begin
          state_d = StRun;
          psc_d   = '0;
          load    = 1'b1;
        end
        OP_STOP: begin
          if (state_q == StRun) state_d = StIdle;
        end
        OP_LOAD_CFG: begin
          if (state_q == StRun) begin
            err_d = 1'b1;
          end else begin
            limit_d    = cfg_limit;
            dir_d      = cfg_dir;
            oneshot_d  = cfg_oneshot;
            prescale_d = cfg_prescale;
          end
        end
      endcase
    end else if (state_q == StRun) begin
      if (psc_q == prescale_q) begin
        psc_d = '0;
        if (at_terminal) begin
          tc_d = 1'b1;
          if (oneshot_q) state_d = StDone;
          else           load    = 1'b1;
        end else begin
          enable = 1'b1;
        end
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      psc_q      <= '0;
      limit_q    <= {WIDTH{CFG_LIMIT_RST_FILL}};
      dir_q      <= CFG_DIR_RST;
      oneshot_q  <= CFG_ONESHOT_RST;
      prescale_q <= {PRESCALE_W{CFG_PRESCALE_RST_FILL}};
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psc_q      <= psc_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      oneshot_q  <= oneshot_d;
      prescale_q <= prescale_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ~reset;
  assign tc_pulse  = tc_q;
  assign cmd_err   = err_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven controller that sequences and configures a 4-bit loadable up/down counter.
- Provides the modulo limit, count direction, one-shot or periodic mode, and a prescaled step rate.
- Exposes the count on y, plus terminal-count and completion status.
- Sits between a host/command source and counter-based timing logic.

Parameters:
- WIDTH, 4, counter width (y, cfg_limit).
- PRESCALE_W, 4, width of the prescale divider field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  always 1 outside reset; a command is accepted when cmd_valid=1 on a clock edge.
- cmd_op  in  2  0=CLEAR, 1=START, 2=STOP, 3=LOAD_CFG.
- cfg_limit  in  WIDTH  modulo limit; sampled on LOAD_CFG.
- cfg_dir  in  1  0=up, 1=down; sampled on LOAD_CFG.
- cfg_oneshot  in  1  1=stop at first terminal count; sampled on LOAD_CFG.
- cfg_prescale  in  PRESCALE_W  step every cfg_prescale+1 cycles; sampled on LOAD_CFG.
- y  out  WIDTH  current count, registered.
- tc_pulse  out  1  one-cycle terminal-count pulse, registered.
- busy  out  1  1 in RUN.
- done  out  1  1 in DONE (one-shot complete).
- cmd_err  out  1  one-cycle pulse: LOAD_CFG rejected.

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high. It takes effect immediately, including mid-run.
- Reset values:
  - Outputs: y=0, tc_pulse=0, busy=0, done=0, cmd_err=0.
  - State: state=IDLE, prescale counter=0.
  - Config: limit=all ones (15), dir=up, oneshot=0, prescale=0.
- FSM states: IDLE, RUN, DONE.
  - busy = (state==RUN).
  - done = (state==DONE).
- Start value: 0 if dir=up, limit if dir=down.
- Terminal value: limit if dir=up, 0 if dir=down.
- CLEAR (any state) -> IDLE; y=0, prescale counter=0. Config is retained.
- START (any state) -> RUN; y=start value, prescale counter=0. Latency: accepted at edge N, so y=start value and busy=1 after edge N.
- STOP:
  - In RUN -> IDLE, y holds its value.
  - In IDLE/DONE: no effect.
- LOAD_CFG:
  - In IDLE/DONE: latches all cfg_* fields; y unchanged.
  - In RUN: ignored, config unchanged, cmd_err=1 for one cycle.
- Step rule in RUN:
  - Prescale counter counts 0..prescale.
  - A step occurs on the cycle the prescale counter equals prescale; the counter then returns to 0.
  - With prescale=0, y changes every cycle.
- Step, y != terminal: y+1 (up) or y-1 (down).
- Step, y == terminal:
  - tc_pulse=1 on the next cycle (single cycle).
  - Periodic: y=start value, stay in RUN.
  - One-shot: y holds terminal, go to DONE.
- limit=0: every step is terminal.
  - Periodic: tc_pulse on every step, y stays 0.
- Arithmetic:
  - All modulo 2^WIDTH; no out-of-range y is possible.
  - y only moves between start and terminal values.
  - If LOAD_CFG reduces limit while in IDLE with y > new limit, y is left as is until the next START/CLEAR.
- Simultaneous events:
  - An accepted command in the same cycle as a step takes precedence.
  - The step is discarded and no tc_pulse is generated.
  - cmd_valid with cmd_op out of range cannot occur (2-bit encoding is complete).
- DONE holds y and done until CLEAR, START, or reset.

Decomposition:
- Package counter_seq_pkg:
  - cmd_op encoding constants (OP_CLEAR, OP_START, OP_STOP, OP_LOAD_CFG).
  - FSM state encoding.
  - Reset defaults for config registers.
- Sub-module counter_core:
  - Ports: WIDTH-bit register with load, load_value, enable, dir.
  - Output: at_terminal flag comparing against a supplied terminal value.
- counter_seq_ctrl owns the FSM, config registers, prescaler, command decode, and pulse generation.

Test Plan:
- Reset defaults: assert reset for 100 ns with clk toggling -> y=0, busy=0, done=0, tc_pulse=0, cmd_err=0. Apply START with defaults -> y counts 0..15 then wraps to 0, tc_pulse once per 16 cycles.
- LOAD_CFG limit=5, dir=up, oneshot=0, prescale=0, then START -> y sequence 0,1,2,3,4,5,0,1,... with tc_pulse high only in cycles where y has just returned to 0 (period 6).
- LOAD_CFG limit=3, dir=down, oneshot=1, prescale=2, then START:
  - y=3,3,3,2,2,2,1,1,1,0,0,0, then tc_pulse=1 once, done=1, busy=0, y stays 0.
  - A subsequent START restarts at y=3.
- During RUN issue LOAD_CFG limit=9 -> cmd_err=1 for exactly one cycle; counting continues with the old limit. STOP -> busy=0, y frozen. LOAD_CFG now accepted with cmd_err=0.
- Collision: periodic up, limit=2, prescale=0; issue CLEAR on the cycle y==2 -> next cycle y=0, state IDLE, tc_pulse=0.
- Assert reset asynchronously mid-count (y=4, between clock edges) -> y=0, busy=0 immediately without waiting for a clock edge; config returns to limit=15, up, periodic, prescale=0.
